bidir_tsb: RTL and testbench



---
 rtl/bidir_tsb_pkg.sv | 13 +
 rtl/bidir_tsb_ctrl.sv | 26 ++
 rtl/bidir_tsb.sv | 38 +++
 tb/tb_bidir_tsb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bidir_tsb_pkg.sv
// bidir_tsb_pkg: state encoding and cfg request codes for the bidirectional tri-state buffer
package bidir_tsb_pkg;
    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_A2B  = 2'b10,
        ST_B2A  = 2'b01,
        ST_TURN = 2'b11
    } state_t;
    localparam logic [1:0] CFG_OFF = 2'b00;
    localparam logic [1:0] CFG_A2B = 2'b10;
    localparam logic [1:0] CFG_B2A = 2'b01;
    localparam logic [1:0] CFG_ILL = 2'b11;
endpackage

// File: rtl/bidir_tsb_ctrl.sv
// bidir_tsb_ctrl: direction state register with one-cycle turnaround on reversal, decoded drive enables
module bidir_tsb_ctrl
    import bidir_tsb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cfg,
    output state_t     state,
    output logic       en_ab,
    output logic       en_ba
);
    state_t from_off;
    state_t state_nx;
    always_comb begin
        from_off = cfg == CFG_A2B ? ST_A2B : cfg == CFG_B2A ? ST_B2A : ST_OFF;
        state_nx = state == ST_A2B ? (cfg == CFG_A2B ? ST_A2B : cfg == CFG_B2A ? ST_TURN : ST_OFF) :
                   state == ST_B2A ? (cfg == CFG_B2A ? ST_B2A : cfg == CFG_A2B ? ST_TURN : ST_OFF) :
                   from_off;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= ST_OFF;
        else     state <= state_nx;
    end
    assign en_ab = state == ST_A2B;
    assign en_ba = state == ST_B2A;
endmodule

// File: rtl/bidir_tsb.sv
// bidir_tsb: bidirectional tri-state buffer a<->b; define BIDIR_TSB_STATUS_EN to add dir/cfg_err outputs
module bidir_tsb
    import bidir_tsb_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cfg,
    inout  wire  [WIDTH-1:0] a,
    inout  wire  [WIDTH-1:0] b
`ifdef BIDIR_TSB_STATUS_EN
    ,
    output logic [1:0]       dir,
    output logic             cfg_err
`endif
);
    state_t state;
    logic   en_ab;
    logic   en_ba;
    bidir_tsb_ctrl u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .cfg   (cfg),
        .state (state),
        .en_ab (en_ab),
        .en_ba (en_ba)
    );
    assign b = en_ab ? a : {WIDTH{1'bz}};
    assign a = en_ba ? b : {WIDTH{1'bz}};
`ifdef BIDIR_TSB_STATUS_EN
    assign dir = state;
    always_ff @(posedge clk) begin
        if (rst)                 cfg_err <= 1'b0;
        else if (cfg == CFG_ILL) cfg_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_bidir_tsb.sv
// tb_bidir_tsb: randomized self-checking bench for bidir_tsb against a mode-level reference model
module tb_bidir_tsb;
    localparam int W = 8;
    localparam int M_OFF = 0, M_A2B = 1, M_B2A = 2, M_TURN = 3;
    localparam logic [1:0] DIRS [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] cfg = 2'b00;
    logic [W-1:0] a_drv = '0, b_drv = '0;
    logic a_oe = 1'b0, b_oe = 1'b0;
    wire [W-1:0] a, b;
    int n_cmp = 0, n_err = 0;
    int mode = M_OFF;
    bit err_m = 1'b0;
    logic [W-1:0] exp_a, exp_b;
    assign a = a_oe ? a_drv : {W{1'bz}};
    assign b = b_oe ? b_drv : {W{1'bz}};
`ifdef BIDIR_TSB_STATUS_EN
    wire [1:0] dir;
    wire cfg_err;
`endif
    bidir_tsb #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg     (cfg),
        .a       (a),
        .b       (b)
`ifdef BIDIR_TSB_STATUS_EN
        ,
        .dir     (dir),
        .cfg_err (cfg_err)
`endif
    );
    always #5 clk = ~clk;
    // Both sides driven at once would be a bus fight; checked every cycle
    always @(negedge clk) begin
        n_cmp++;
        if (dut.en_ab === 1'b1 && dut.en_ba === 1'b1) begin
            n_err++;
            $display("FAIL both_enables: en_ab=%b en_ba=%b required not both 1", dut.en_ab, dut.en_ba);
        end
    end
    // Bench drives every side the model says the DUT leaves undriven, with opposite data on each side
    task automatic set_sides(input logic [W-1:0] p);
        a_drv = p;
        b_drv = ~p;
        a_oe = mode != M_B2A;
        b_oe = mode != M_A2B;
        exp_a = mode == M_B2A ? b_drv : a_drv;
        exp_b = mode == M_A2B ? a_drv : b_drv;
    endtask
    task automatic apply(input logic [1:0] c, input logic r);
        int req;
        @(negedge clk);
        cfg = c;
        rst = r;
        @(posedge clk);
        if (r) begin
            mode = M_OFF;
            err_m = 1'b0;
        end else begin
            if (c == 2'b11) err_m = 1'b1;
            req = c == 2'b10 ? M_A2B : c == 2'b01 ? M_B2A : M_OFF;
            mode = ((mode == M_A2B && req == M_B2A) || (mode == M_B2A && req == M_A2B)) ? M_TURN : req;
        end
        #1 set_sides(W'($urandom));
        #1;
    endtask
    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            apply(2'b10, 1'b1);
            n_cmp++;
            if (a !== exp_a || b !== exp_b) begin
                n_err++;
                $display("FAIL reset: a=%h b=%h required a=%h b=%h", a, b, exp_a, exp_b);
            end
`ifdef BIDIR_TSB_STATUS_EN
            n_cmp++;
            if (dir !== DIRS[mode] || cfg_err !== err_m) begin
                n_err++;
                $display("FAIL reset_status: dir=%b err=%b required dir=%b err=%b", dir, cfg_err, DIRS[mode], err_m);
            end
`endif
        end
    endtask
    task automatic test_off;
        for (int i = 0; i < 4; i++) begin
            apply(2'b00, 1'b0);
            n_cmp++;
            if (a !== exp_a || b !== exp_b) begin
                n_err++;
                $display("FAIL off: a=%h b=%h required a=%h b=%h", a, b, exp_a, exp_b);
            end
        end
    endtask
    task automatic test_a2b;
        apply(2'b10, 1'b0);
        for (int i = 0; i < 6; i++) begin
            set_sides(i < 2 ? {W{i[0]}} : W'($urandom));
            #1;
            n_cmp++;
            if (a !== exp_a || b !== exp_b) begin
                n_err++;
                $display("FAIL a2b: a=%h b=%h required a=%h b=%h", a, b, exp_a, exp_b);
            end
        end
    endtask
    task automatic test_b2a;
        apply(2'b00, 1'b0);
        apply(2'b01, 1'b0);
        for (int i = 0; i < 6; i++) begin
            set_sides(i < 2 ? {W{~i[0]}} : W'($urandom));
            #1;
            n_cmp++;
            if (a !== exp_a || b !== exp_b) begin
                n_err++;
                $display("FAIL b2a: a=%h b=%h required a=%h b=%h", a, b, exp_a, exp_b);
            end
        end
    endtask
    task automatic test_turnaround;
        logic [1:0] seq [5] = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
        for (int i = 0; i < 5; i++) begin
            apply(seq[i], 1'b0);
            n_cmp++;
            if (a !== exp_a || b !== exp_b) begin
                n_err++;
                $display("FAIL turn step%0d: a=%h b=%h required a=%h b=%h", i, a, b, exp_a, exp_b);
            end
`ifdef BIDIR_TSB_STATUS_EN
            n_cmp++;
            if (dir !== DIRS[mode]) begin
                n_err++;
                $display("FAIL turn_dir step%0d: dir=%b required %b", i, dir, DIRS[mode]);
            end
`endif
        end
    endtask
    task automatic test_illegal;
        logic [1:0] cs [5] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00};
        logic       rs [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            apply(cs[i], rs[i]);
            n_cmp++;
            if (a !== exp_a || b !== exp_b) begin
                n_err++;
                $display("FAIL illegal step%0d: a=%h b=%h required a=%h b=%h", i, a, b, exp_a, exp_b);
            end
`ifdef BIDIR_TSB_STATUS_EN
            n_cmp++;
            if (cfg_err !== err_m || dir !== DIRS[mode]) begin
                n_err++;
                $display("FAIL illegal_status step%0d: err=%b dir=%b required err=%b dir=%b", i, cfg_err, dir, err_m, DIRS[mode]);
            end
`endif
        end
    endtask
    task automatic test_reset_in_turn;
        logic [1:0] cs [4] = '{2'b10, 2'b01, 2'b10, 2'b10};
        logic       rs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            apply(cs[i], rs[i]);
            n_cmp++;
            if (a !== exp_a || b !== exp_b) begin
                n_err++;
                $display("FAIL reset_in_turn step%0d: a=%h b=%h required a=%h b=%h", i, a, b, exp_a, exp_b);
            end
        end
    endtask
    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            apply(2'($urandom_range(0, 3)), $urandom_range(0, 24) == 0);
            n_cmp++;
            if (a !== exp_a || b !== exp_b) begin
                n_err++;
                $display("FAIL random cyc%0d: a=%h b=%h required a=%h b=%h", i, a, b, exp_a, exp_b);
            end
`ifdef BIDIR_TSB_STATUS_EN
            n_cmp++;
            if (dir !== DIRS[mode] || cfg_err !== err_m) begin
                n_err++;
                $display("FAIL random_status cyc%0d: dir=%b err=%b required dir=%b err=%b", i, dir, cfg_err, DIRS[mode], err_m);
            end
`endif
        end
    endtask
    initial begin
        test_reset;
        test_off;
        test_a2b;
        test_b2a;
        test_turnaround;
        test_illegal;
        test_reset_in_turn;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
